stack_sequencer: RTL

Multi-cycle sequencer driving the stack side of the RNBIP-2 data memory for PUSH, POP, CALL and RET. Sits directly upstream of the data memory:
- owns the stack pointer and supplies it as the memory's SP address;
- drives the SP/R0 address select (S2) and the RN/NPC write-data select (S5);
- issues stack write and read strobes;
- returns popped bytes (RET targets) to the control unit.

---
 rtl/rnbip_stack_pkg.sv | 35 +++
 rtl/stack_pointer_reg.sv | 36 +++
 rtl/stack_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rnbip_stack_pkg.sv
// -----------------------------------------------------------------------------
// rnbip_stack_pkg
// Shared definitions for the RNBIP-2 stack sequencer: operation encodings,
// sequencer state enumeration and the default stack bounds.
// No ports (package).
// -----------------------------------------------------------------------------
package rnbip_stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEC,
    ST_WRITE,
    ST_READ,
    ST_INC,
    ST_ERR
  } state_t;

  // SP value after reset; SP equal to this means the stack is empty.
  localparam logic [7:0] SP_RESET_DEFAULT    = 8'hFF;
  // Lowest valid stack address; SP equal to this means the stack is full.
  localparam logic [7:0] STACK_LIMIT_DEFAULT = 8'h80;

  // PUSH and CALL write the stack; POP and RET read it.
  function automatic logic is_write_op(input op_code_t op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_pointer_reg.sv
// -----------------------------------------------------------------------------
// stack_pointer_reg
// 8-bit stack pointer with decrement/increment controls and full/empty flags.
//   clk, rst_n : clock, synchronous active-low reset (SP <= SP_RESET)
//   dec, inc   : SP <= SP-1 / SP+1 on the next edge (dec has priority)
//   sp         : current stack pointer
//   is_full    : sp == STACK_LIMIT
//   is_empty   : sp == SP_RESET
// -----------------------------------------------------------------------------
module stack_pointer_reg
  import rnbip_stack_pkg::*;
#(
  parameter logic [7:0] SP_RESET    = SP_RESET_DEFAULT,
  parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec,
  input  logic       inc,
  output logic [7:0] sp,
  output logic       is_full,
  output logic       is_empty
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n)   sp <= SP_RESET;
    else if (dec) sp <= sp - 8'd1;   // modulo-256 wrap is intentional
    else if (inc) sp <= sp + 8'd1;
  end

  assign is_full  = (sp == STACK_LIMIT);
  assign is_empty = (sp == SP_RESET);

endmodule

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
// Multi-cycle PUSH/POP/CALL/RET sequencer for the stack side of the RNBIP-2
// data memory. Full-descending stack: PUSH pre-decrements, POP post-increments.
// Optional feature macro: STACK_GUARD_EN (full/empty checks, ERR state and
// sticky stk_err). Without it SP wraps freely and stk_err is tied low.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   op_valid/ready : request handshake, accepted when both high on an edge
//   op_code        : 00 PUSH, 01 POP, 10 CALL, 11 RET
//   op_done        : pulse on the final cycle of each accepted operation
//   mem_data_in    : combinational memory read data
//   SP_out         : stack pointer (memory SP address)
//   S2             : address select, 1 = SP (WRITE/READ only)
//   S5             : write-data select, 1 = RN (PUSH), 0 = NPC (CALL)
//   stk_WR, stk_RD : stack write/read strobes
//   pop_data       : byte captured by the last POP/RET
//   pc_load        : with op_done for RET; pop_data is the new PC
//   err_clr        : clears stk_err
//   stk_err        : sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module stack_sequencer
  import rnbip_stack_pkg::*;
#(
  parameter logic [7:0] SP_RESET    = SP_RESET_DEFAULT,
  parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  output logic       op_ready,
  output logic       op_done,
  input  logic [7:0] mem_data_in,
  output logic [7:0] SP_out,
  output logic       S2,
  output logic       S5,
  output logic       stk_WR,
  output logic       stk_RD,
  output logic [7:0] pop_data,
  output logic       pc_load,
  input  logic       err_clr,
  output logic       stk_err
);

  state_t   state, state_nx;
  op_code_t op_q;
  op_code_t op_in;
  logic     sp_dec, sp_inc;
  logic     is_full, is_empty;
  logic     guard_fail;

  assign op_in    = op_code_t'(op_code);
  assign op_ready = (state == ST_IDLE);

  stack_pointer_reg #(
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (sp_dec),
    .inc      (sp_inc),
    .sp       (SP_out),
    .is_full  (is_full),
    .is_empty (is_empty)
  );

`ifdef STACK_GUARD_EN
  // Guard is evaluated against the incoming request at acceptance time.
  assign guard_fail = is_write_op(op_in) ? is_full : is_empty;

  // Set (from the ERR cycle) takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n)                 stk_err <= 1'b0;
    else if (state == ST_ERR)   stk_err <= 1'b1;
    else if (err_clr)           stk_err <= 1'b0;
  end
`else
  assign guard_fail = 1'b0;
  assign stk_err    = 1'b0;
  logic unused_guard;
  assign unused_guard = ^{err_clr, is_full, is_empty};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_PUSH;
      pop_data <= 8'h00;
    end else begin
      state <= state_nx;
      if (op_valid && op_ready) op_q     <= op_in;
      if (state == ST_READ)     pop_data <= mem_data_in;
    end
  end

  // Strobes and selects are decoded from state alone, so a WRITE cycle that
  // coincides with reset still writes on that edge.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nx = state;
    op_done  = 1'b0;
    pc_load  = 1'b0;
    S2       = 1'b0;
    S5       = 1'b0;
    stk_WR   = 1'b0;
    stk_RD   = 1'b0;
    sp_dec   = 1'b0;
    sp_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (op_valid) begin
          if (guard_fail)             state_nx = ST_ERR;
          else if (is_write_op(op_in)) state_nx = ST_DEC;
          else                         state_nx = ST_READ;
        end
      end
      ST_DEC: begin
        sp_dec   = 1'b1;
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        S2       = 1'b1;
        stk_WR   = 1'b1;
        S5       = (op_q == OP_PUSH);
        op_done  = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_READ: begin
        S2       = 1'b1;
        stk_RD   = 1'b1;
        state_nx = ST_INC;
      end
      ST_INC: begin
        sp_inc   = 1'b1;
        op_done  = 1'b1;
        pc_load  = (op_q == OP_RET);
        state_nx = ST_IDLE;
      end
      ST_ERR: begin
        op_done  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
